debounce_multi: RTL and testbench

- N-channel successor to the single-button debouncer. Each channel has its own 2-FF synchroniser and an independent stability timer.
- Adds per-channel press/release event pulses, long-press detection and auto-repeat.
- Selectable input polarity.
- Sits between raw board pushbuttons and user logic: counters, PWM duty control, menu FSMs.

---
 rtl/debounce_multi.sv | 120 ++++++++++++
 tb/tb_debounce_multi.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// Multi-channel pushbutton debouncer: per-channel 2-FF synchroniser, stability timer,
// press/release strobes, long-press level and auto-repeat strobes.
module debounce_multi #(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int DEBOUNCE_MS = 10,
    parameter int CHANNELS    = 4,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_MS   = 200,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] button_in,
    output logic [CHANNELS-1:0] button_out,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] long_press,
    output logic [CHANNELS-1:0] repeat_pulse
);

    localparam int DB_CYC     = (CLK_FREQ / 1000) * DEBOUNCE_MS;
    localparam int LONG_CYC   = (CLK_FREQ / 1000) * LONG_MS;
    localparam int REPEAT_CYC = (CLK_FREQ / 1000) * REPEAT_MS;

    localparam int DB_W   = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
    localparam int HOLD_W = $clog2(LONG_CYC + 1);
    localparam int REP_W  = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYC - 1);
    localparam logic [HOLD_W-1:0] LONG_SAT  = HOLD_W'(LONG_CYC);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYC - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'((REPEAT_CYC > 0) ? REPEAT_CYC - 1 : 0);
    localparam logic              REP_EN    = (REPEAT_CYC > 0);
    localparam logic              INVERT    = (ACTIVE_LOW != 0);

    if (DB_CYC < 1) begin : g_bad_db
        $error("debounce_multi: DB_CYC must be >= 1");
    end
    if (LONG_CYC < 1) begin : g_bad_long
        $error("debounce_multi: LONG_CYC must be >= 1");
    end

    logic [CHANNELS-1:0] in_n;
    logic [CHANNELS-1:0] sync0;
    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] flip;
    logic [DB_W-1:0]     db_cnt   [CHANNELS];
    logic [HOLD_W-1:0]   hold_cnt [CHANNELS];
    logic [REP_W-1:0]    rep_cnt  [CHANNELS];

    assign in_n = button_in ^ {CHANNELS{INVERT}};

    // A channel's debounced level flips on this edge once the new level has survived DB_CYC samples.
    always_comb begin
        flip = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            flip[c] = (sync1[c] != button_out[c]) && (db_cnt[c] == DB_LAST);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync0         <= '0;
            sync1         <= '0;
            button_out    <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            long_press    <= '0;
            repeat_pulse  <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                db_cnt[c]   <= '0;
                hold_cnt[c] <= '0;
                rep_cnt[c]  <= '0;
            end
        end else begin
            sync0 <= in_n;
            sync1 <= sync0;
            for (int c = 0; c < CHANNELS; c++) begin
                press_pulse[c]   <= 1'b0;
                release_pulse[c] <= 1'b0;
                repeat_pulse[c]  <= 1'b0;

                if (flip[c]) begin
                    button_out[c]    <= sync1[c];
                    press_pulse[c]   <= sync1[c];
                    release_pulse[c] <= ~sync1[c];
                    db_cnt[c]        <= '0;
                end else if (sync1[c] != button_out[c]) begin
                    db_cnt[c] <= db_cnt[c] + 1'b1;
                end else begin
                    db_cnt[c] <= '0;
                end

                // Any level change restarts the hold/repeat machinery; a fall also drops long_press.
                if (flip[c]) begin
                    hold_cnt[c]   <= '0;
                    rep_cnt[c]    <= '0;
                    long_press[c] <= 1'b0;
                end else if (button_out[c]) begin
                    if (hold_cnt[c] != LONG_SAT) begin
                        hold_cnt[c] <= hold_cnt[c] + 1'b1;
                    end
                    if (hold_cnt[c] == LONG_LAST) begin
                        long_press[c]   <= 1'b1;
                        repeat_pulse[c] <= REP_EN;
                        rep_cnt[c]      <= '0;
                    end else if (long_press[c] && REP_EN) begin
                        if (rep_cnt[c] == REP_LAST) begin
                            rep_cnt[c]      <= '0;
                            repeat_pulse[c] <= 1'b1;
                        end else begin
                            rep_cnt[c] <= rep_cnt[c] + 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed self-checking bench for debounce_multi: one active-high and one active-low instance
// at 1 cycle/ms, DB=4, LONG=20, REPEAT=5.
module tb_debounce_multi;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] button_in;
    logic [3:0] button_out, press_pulse, release_pulse, long_press, repeat_pulse;
    logic [3:0] button_in_al;
    logic [3:0] button_out_al, press_pulse_al, release_pulse_al, long_press_al, repeat_pulse_al;

    int check_count = 0;
    int error_count = 0;

    always #5 clk = ~clk;

    debounce_multi #(
        .CLK_FREQ(1000), .DEBOUNCE_MS(4), .CHANNELS(4),
        .LONG_MS(20), .REPEAT_MS(5), .ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .button_in(button_in),
        .button_out(button_out), .press_pulse(press_pulse),
        .release_pulse(release_pulse), .long_press(long_press),
        .repeat_pulse(repeat_pulse)
    );

    debounce_multi #(
        .CLK_FREQ(1000), .DEBOUNCE_MS(4), .CHANNELS(4),
        .LONG_MS(20), .REPEAT_MS(5), .ACTIVE_LOW(1)
    ) dut_al (
        .clk(clk), .reset_n(reset_n), .button_in(button_in_al),
        .button_out(button_out_al), .press_pulse(press_pulse_al),
        .release_pulse(release_pulse_al), .long_press(long_press_al),
        .repeat_pulse(repeat_pulse_al)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] raw, input logic [3:0] raw_al);
        button_in    = raw;
        button_in_al = raw_al;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Bounce pattern: high 3 samples, low 1, high 3, then low.
    function automatic logic bounce_bit(input int k);
        return (k < 3) || (k >= 4 && k < 7);
    endfunction

    initial begin
        logic [3:0] acc;
        logic       acc1;

        reset_n = 1'b0;
        applyStimulus(4'b0000, 4'b1111);
        tick(3);
        checkOutput("reset_outputs", {button_out, press_pulse, release_pulse, long_press, repeat_pulse}, 20'h0);
        reset_n = 1'b1;

        acc = '0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            acc |= button_out | press_pulse | release_pulse | button_out_al | press_pulse_al | release_pulse_al;
        end
        checkOutput("reset_exit_quiet", acc, 4'h0);

        // 1. Clean press and release on channel 0
        $display("[TB] clean press");
        applyStimulus(4'b0001, 4'b1111);
        tick(5);
        checkOutput("press_before_latency", button_out, 4'b0000);
        tick(1);
        checkOutput("press_level", button_out, 4'b0001);
        checkOutput("press_pulse", press_pulse, 4'b0001);
        tick(1);
        checkOutput("press_pulse_one_cycle", press_pulse, 4'b0000);
        checkOutput("press_level_held", button_out, 4'b0001);
        applyStimulus(4'b0000, 4'b1111);
        tick(5);
        checkOutput("release_before_latency", button_out, 4'b0001);
        tick(1);
        checkOutput("release_level", button_out, 4'b0000);
        checkOutput("release_pulse", release_pulse, 4'b0001);
        tick(1);
        checkOutput("release_pulse_one_cycle", release_pulse, 4'b0000);
        checkOutput("short_no_long", long_press, 4'b0000);
        tick(5);

        // 2. Bounce on channel 1 never gets through
        $display("[TB] bounce");
        acc = '0;
        for (int k = 0; k < 16; k++) begin
            applyStimulus({2'b00, bounce_bit(k), 1'b0}, 4'b1111);
            tick(1);
            acc |= button_out | press_pulse | release_pulse;
        end
        checkOutput("bounce_rejected", acc, 4'h0);

        // 4. Channels 0 and 3 together while channel 1 bounces
        $display("[TB] multi-channel");
        acc1 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            applyStimulus({1'b1, 1'b0, bounce_bit(k), 1'b1}, 4'b1111);
            tick(1);
            acc1 |= button_out[1] | press_pulse[1];
            if (k == 4) checkOutput("multi_before", press_pulse, 4'b0000);
            if (k == 5) begin
                checkOutput("multi_press_pulse", press_pulse, 4'b1001);
                checkOutput("multi_level", button_out, 4'b1001);
            end
            if (k == 6) checkOutput("multi_pulse_end", press_pulse, 4'b0000);
        end
        checkOutput("multi_ch1_quiet", acc1, 1'b0);
        applyStimulus(4'b0000, 4'b1111);
        tick(6);
        checkOutput("multi_release_pulse", release_pulse, 4'b1001);
        tick(6);

        // 3. Long press and auto-repeat on channel 2 (k counts edges after the debounced rise)
        $display("[TB] long press");
        applyStimulus(4'b0100, 4'b1111);
        tick(6);
        checkOutput("long_rise_press", press_pulse, 4'b0100);
        for (int k = 1; k <= 39; k++) begin
            if (k == 33) applyStimulus(4'b0000, 4'b1111);
            tick(1);
            checkOutput($sformatf("long_level_%0d", k), long_press[2], (k >= 20 && k < 38));
            checkOutput($sformatf("repeat_%0d", k), repeat_pulse[2],
                        (k == 20 || k == 25 || k == 30 || k == 35));
            if (k >= 37) begin
                checkOutput($sformatf("long_release_pulse_%0d", k), release_pulse[2], (k == 38));
                checkOutput($sformatf("long_level_out_%0d", k), button_out[2], (k < 38));
            end
        end
        tick(5);

        // 5. Reset while long_press is high, raw still held through reset release
        $display("[TB] reset mid-hold");
        applyStimulus(4'b0100, 4'b1111);
        tick(26);
        checkOutput("pre_reset_long", long_press, 4'b0100);
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_clear", {button_out, press_pulse, release_pulse, long_press, repeat_pulse}, 20'h0);
        tick(2);
        reset_n = 1'b1;
        tick(5);
        checkOutput("post_reset_wait", button_out, 4'b0000);
        tick(1);
        checkOutput("post_reset_level", button_out, 4'b0100);
        checkOutput("post_reset_press", press_pulse, 4'b0100);
        tick(19);
        checkOutput("post_reset_long_early", long_press, 4'b0000);
        tick(1);
        checkOutput("post_reset_long", long_press, 4'b0100);
        checkOutput("post_reset_repeat", repeat_pulse, 4'b0100);
        applyStimulus(4'b0000, 4'b1111);
        tick(12);

        // 6. Active-low instance: idle high is released, low is pressed
        $display("[TB] active low");
        checkOutput("al_idle_level", button_out_al, 4'b0000);
        applyStimulus(4'b0000, 4'b1110);
        tick(5);
        checkOutput("al_before_latency", button_out_al, 4'b0000);
        tick(1);
        checkOutput("al_press_pulse", press_pulse_al, 4'b0001);
        checkOutput("al_level", button_out_al, 4'b0001);
        tick(1);
        checkOutput("al_pulse_end", press_pulse_al, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
